// File: rtl/ft_ckpt_memory.sv
// Checkpoint memory: a shadow bank of register-file/PC writes and a committed
// bank filled by a word-per-cycle copy; reads come from the committed bank.
module ft_ckpt_memory #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 32,
    parameter  int ADDR_W   = 32,
    localparam int RF_AW    = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_rf_i,
    input  logic [RF_AW-1:0]  addr_rf_i,
    input  logic [DATA_W-1:0] data_rf_i,
    input  logic              we_pc_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              inj_i,
    input  logic              commit_i,
    output logic              commit_done_o,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(NUM_REGS + 1);
    localparam logic [IDX_W-1:0] PC_IDX = IDX_W'(NUM_REGS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COPY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [DATA_W-1:0] sh_data [NUM_REGS+1];
    logic [DATA_W-1:0] cm_data [NUM_REGS+1];
    logic [NUM_REGS:0] sh_par;
    logic [NUM_REGS:0] cm_par;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;

    logic [IDX_W-1:0]  rf_idx;
    logic [ADDR_W-3:0] rd_word;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_data;
    logic              rd_par;

    assign rf_idx  = IDX_W'(addr_rf_i);
    assign rd_word = addr_i[ADDR_W-1:2];
    assign rd_idx  = rd_word[IDX_W-1:0];
    assign rd_ok   = (addr_i[1:0] == 2'b00)
                  && (rd_word <= (ADDR_W-2)'(NUM_REGS));
    assign rd_data = cm_data[rd_idx];
    assign rd_par  = cm_par[rd_idx];

    // Reset is treated as forcing IDLE for the grant decision.
    assign gnt_o         = req_i && ((state == S_IDLE) || !rst_ni);
    assign commit_done_o = (state == S_DONE);

    // Copy reads the pre-edge shadow value, so a same-cycle write is not seen.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i <= NUM_REGS; i++) begin
                sh_data[i] <= '0;
                cm_data[i] <= '0;
            end
            sh_par <= '0;
            cm_par <= '0;
        end else begin
            if (state == S_COPY) begin
                cm_data[idx] <= sh_data[idx];
                cm_par[idx]  <= sh_par[idx];
            end
            if (we_rf_i && (rf_idx < PC_IDX)) begin
                sh_data[rf_idx] <= data_rf_i;
                sh_par[rf_idx]  <= (^data_rf_i) ^ inj_i;
            end
            if (we_pc_i) begin
                sh_data[PC_IDX] <= pc_i;
                sh_par[PC_IDX]  <= (^pc_i) ^ inj_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (commit_i) begin
                        state <= S_COPY;
                        idx   <= '0;
                    end
                end
                S_COPY: begin
                    if (idx == PC_IDX) begin
                        state <= S_DONE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else if (gnt_o) begin
            rvalid_o <= 1'b1;
            if (!rd_ok) begin
                rdata_o <= '0;
                err_o   <= 1'b1;
            end else begin
                rdata_o <= rd_data;
                err_o   <= (^rd_data) ^ rd_par;
            end
        end else begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ft_ckpt_memory.sv
// Bench for ft_ckpt_memory: vector table, directed commit/reset sequences
// and random traffic against a behavioural model of the two banks.
module tb_ft_ckpt_memory;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        we_rf_i;
    logic [4:0]  addr_rf_i;
    logic [31:0] data_rf_i;
    logic        we_pc_i;
    logic [31:0] pc_i;
    logic        inj_i;
    logic        commit_i;
    logic        commit_done_o;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    ft_ckpt_memory #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .we_rf_i(we_rf_i), .addr_rf_i(addr_rf_i), .data_rf_i(data_rf_i),
        .we_pc_i(we_pc_i), .pc_i(pc_i), .inj_i(inj_i),
        .commit_i(commit_i), .commit_done_o(commit_done_o),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o)
    );

    // Model: m_cnt counts cycles since commit was taken (0 = idle,
    // 1..33 = copying entry m_cnt-1, 34 = completion cycle).
    logic [31:0] sh  [0:32];
    logic [31:0] cm  [0:32];
    logic        shp [0:32];
    logic        cmp [0:32];
    int          m_cnt;
    logic        m_rv;
    logic [31:0] m_rd;
    logic        m_err;

    int   n_vec = 0;
    int   n_bad = 0;
    logic seen_gnt;
    logic seen_done;

    typedef struct {
        logic        we_rf;
        logic [4:0]  a_rf;
        logic [31:0] d_rf;
        logic        req;
        logic [31:0] addr;
        logic        e_gnt;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_err;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic exp_gnt();
        return req_i && ((m_cnt == 0) || !rst_ni);
    endfunction

    task automatic model_edge();
        logic        g;
        logic [31:0] w;
        g = exp_gnt();
        if (!rst_ni) begin
            for (int i = 0; i <= 32; i++) begin
                sh[i] = '0; cm[i] = '0; shp[i] = 1'b0; cmp[i] = 1'b0;
            end
            m_cnt = 0; m_rv = 1'b0; m_rd = '0; m_err = 1'b0;
            return;
        end
        w = addr_i >> 2;
        if (!g) begin
            m_rv = 1'b0; m_rd = '0; m_err = 1'b0;
        end else if (addr_i[1:0] != 2'b00 || w > 32) begin
            m_rv = 1'b1; m_rd = '0; m_err = 1'b1;
        end else begin
            m_rv = 1'b1; m_rd = cm[w]; m_err = (^cm[w]) ^ cmp[w];
        end
        if (m_cnt >= 1 && m_cnt <= 33) begin
            cm[m_cnt-1]  = sh[m_cnt-1];
            cmp[m_cnt-1] = shp[m_cnt-1];
        end
        if (we_rf_i) begin
            sh[addr_rf_i]  = data_rf_i;
            shp[addr_rf_i] = (^data_rf_i) ^ inj_i;
        end
        if (we_pc_i) begin
            sh[32]  = pc_i;
            shp[32] = (^pc_i) ^ inj_i;
        end
        if (m_cnt == 0) m_cnt = commit_i ? 1 : 0;
        else            m_cnt = (m_cnt == 34) ? 0 : m_cnt + 1;
    endtask

    // One clock: check combinational outputs, take the edge, check registers.
    task automatic cycle();
        #1;
        seen_gnt  = gnt_o;
        seen_done = commit_done_o;
        chk("gnt", {31'b0, gnt_o}, {31'b0, exp_gnt()});
        chk("commit_done", {31'b0, commit_done_o}, {31'b0, m_cnt == 34});
        @(posedge clk_i);
        model_edge();
        #2;
        chk("rvalid", {31'b0, rvalid_o}, {31'b0, m_rv});
        chk("rdata", rdata_o, m_rd);
        chk("err", {31'b0, err_o}, {31'b0, m_err});
    endtask

    task automatic idle_inputs();
        we_rf_i = 0; addr_rf_i = '0; data_rf_i = '0; we_pc_i = 0;
        pc_i = '0; inj_i = 0; commit_i = 0; req_i = 0; addr_i = '0;
    endtask

    task automatic do_commit(input string nm);
        int got;
        got = 0;
        commit_i = 1;
        cycle();
        commit_i = 0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            cycle();
            if (seen_done) got = 1;
        end
        chk(nm, got, 1);
    endtask

    task automatic read_chk(input string nm, input logic [31:0] a,
                            input logic [31:0] d, input logic e);
        req_i = 1; addr_i = a;
        cycle();
        chk({nm, "_rv"}, {31'b0, rvalid_o}, 32'd1);
        chk({nm, "_rd"}, rdata_o, d);
        chk({nm, "_err"}, {31'b0, err_o}, {31'b0, e});
        req_i = 0;
    endtask

    initial begin
        int lows, dones, done_at, r;

        tbl[0] = '{1, 5'd3, 32'hDEAD_BEEF, 1, 32'h0C,   1, 1, 32'h0, 0};
        tbl[1] = '{0, 5'd0, 32'h0,         1, 32'h0C,   1, 1, 32'h0, 0};
        tbl[2] = '{0, 5'd0, 32'h0,         1, 32'h84,   1, 1, 32'h0, 1};
        tbl[3] = '{0, 5'd0, 32'h0,         1, 32'h02,   1, 1, 32'h0, 1};
        tbl[4] = '{0, 5'd0, 32'h0,         1, 32'h80,   1, 1, 32'h0, 0};
        tbl[5] = '{0, 5'd0, 32'h0,         0, 32'h10,   0, 0, 32'h0, 0};
        tbl[6] = '{1, 5'd7, 32'h1234_5678, 1, 32'h7F,   1, 1, 32'h0, 1};
        tbl[7] = '{0, 5'd0, 32'h0,         1, 32'h1000, 1, 1, 32'h0, 1};

        idle_inputs();
        rst_ni = 0;
        m_cnt = 0;
        @(posedge clk_i);
        model_edge();
        #2;
        cycle();
        chk("reset_rvalid", {31'b0, rvalid_o}, 32'd0);
        chk("reset_done", {31'b0, commit_done_o}, 32'd0);
        rst_ni = 1;

        foreach (tbl[i]) begin
            we_rf_i = tbl[i].we_rf; addr_rf_i = tbl[i].a_rf;
            data_rf_i = tbl[i].d_rf; req_i = tbl[i].req;
            addr_i = tbl[i].addr;
            cycle();
            chk($sformatf("tbl%0d_gnt", i), {31'b0, seen_gnt},
                {31'b0, tbl[i].e_gnt});
            chk($sformatf("tbl%0d_rv", i), {31'b0, rvalid_o},
                {31'b0, tbl[i].e_rv});
            chk($sformatf("tbl%0d_rd", i), rdata_o, tbl[i].e_rd);
            chk($sformatf("tbl%0d_err", i), {31'b0, err_o},
                {31'b0, tbl[i].e_err});
        end
        idle_inputs();

        // Commit with a read pending the whole time.
        req_i = 1; addr_i = 32'h0C; commit_i = 1;
        cycle();
        chk("precommit_read", rdata_o, 32'h0);
        commit_i = 0;
        lows = 0; dones = 0; done_at = 0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (!seen_gnt) lows++;
            if (seen_done) begin
                dones++;
                done_at = c + 1;
            end
            if (seen_gnt) break;
        end
        chk("busy_cycles", lows, 34);
        chk("done_pulses", dones, 1);
        chk("done_position", done_at, 34);
        chk("postcommit_read", rdata_o, 32'hDEAD_BEEF);
        idle_inputs();

        for (int i = 0; i < 32; i++) begin
            we_rf_i = 1; addr_rf_i = 5'(i); data_rf_i = 32'h1111_1100 + i;
            cycle();
        end
        we_rf_i = 0; we_pc_i = 1; pc_i = 32'h80;
        cycle();
        we_pc_i = 0;
        do_commit("commit21");
        for (int i = 0; i <= 32; i++)
            read_chk($sformatf("r21_%0d", i), 32'(4 * i),
                     (i < 32) ? 32'h1111_1100 + i : 32'h80, 1'b0);

        we_rf_i = 1; addr_rf_i = 5'd5; data_rf_i = 32'h5A5A_0005; inj_i = 1;
        cycle();
        idle_inputs();
        do_commit("commit23");
        read_chk("inj", 32'h14, 32'h5A5A_0005, 1'b1);

        commit_i = 1;
        cycle();
        commit_i = 0;
        for (int c = 0; c < 10; c++) cycle();
        rst_ni = 0; req_i = 1; addr_i = 32'h14;
        cycle();
        chk("reset_gnt", {31'b0, seen_gnt}, 32'd1);
        chk("reset_rv", {31'b0, rvalid_o}, 32'd0);
        rst_ni = 1; req_i = 0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (seen_done) dones++;
        end
        chk("abort_no_done", dones, 0);
        read_chk("abort_r14", 32'h14, 32'h0, 1'b0);
        read_chk("abort_r0", 32'h0, 32'h0, 1'b0);
        read_chk("abort_r80", 32'h80, 32'h0, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            rst_ni    = ($urandom_range(0, 199) != 0);
            we_rf_i   = 1'($urandom);
            addr_rf_i = 5'($urandom);
            data_rf_i = $urandom;
            we_pc_i   = ($urandom_range(0, 3) == 0);
            pc_i      = $urandom;
            inj_i     = ($urandom_range(0, 9) == 0);
            commit_i  = ($urandom_range(0, 29) == 0);
            req_i     = 1'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7)      addr_i = 32'($urandom_range(0, 32)) << 2;
            else if (r < 9) addr_i = 32'($urandom_range(0, 255));
            else            addr_i = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
